decode_ctrl_stage: RTL
======================

Name: decode_ctrl_stage

Overview:
- Registered instruction-decode control stage for the pipelined RV32I/M core; successor to the combinational opcode decoder.
- Decodes a 32-bit instruction into the control bundle and holds it in the ID/EX pipeline register.
- Detects load-use hazards, sequences multi-cycle MUL/DIV occupancy of EX, and applies flushes.
- Sits between the IF/ID register and the execute stage.

Parameters:
REG_ADDR_W, 5, register index width (4 selects RV32E).
ENABLE_M, 1, 1 = decode M-extension ops; 0 = treat them as illegal.
MUL_LATENCY, 3, EX occupancy in cycles of MUL* ops (≥1).
DIV_LATENCY, 34, EX occupancy in cycles of DIV/REM* ops (≥1).

Ports:
clk_i  in  1  clock, rising edge.
rst_n_i  in  1  asynchronous active-low reset.
valid_i  in  1  instr_i holds a valid instruction.
instr_i  in  32  instruction from IF/ID.
flush_i  in  1  redirect from EX/trap; kill the instruction in ID and EX.
stall_o  out  1  combinational; IF/ID must hold its contents.
ex_valid_o  out  1  EX slot holds a real instruction.
ex_alu_op_o  out  4  ALU op class.
ex_imm_select_o  out  3  immediate format.
ex_alu_src_o, ex_alu_pc_o, ex_add_sum_reg_o, ex_reg_write_o, ex_mem_rd_o, ex_mem_wr_o, ex_mem_to_reg_o, ex_branch_o  out  1 each  control flags.
ex_muldiv_o  out  1  EX holds an M op.
ex_illegal_o  out  1  EX holds an undecodable valid instruction.
ex_rd_o, ex_rs1_o, ex_rs2_o  out  REG_ADDR_W  register indices (instr bits [11:7], [19:15], [24:20], truncated).
ex_funct3_o  out  3  instr[14:12].
ex_funct7_o  out  7  instr[31:25].

Behaviour:
- Reset (async, rst_n_i=0): all ex_* outputs = 0; MUL/DIV counter = 0. stall_o is then 0 by construction.
- Decode, by opcode. Flags not listed are 0; imm_select is 000 (I format) unless stated.
  - 0000000: bubble, not illegal.
  - 0110011 (R-type): alu_op 0000, reg_write.
  - 0010011 (I-arith): alu_op 0101, alu_src, reg_write.
  - 0000011 (load): alu_op 0110, alu_src, reg_write, mem_rd, mem_to_reg.
  - 0100011 (store): alu_op 0110, alu_src, mem_wr, imm 001.
  - 1100011 (branch): alu_op 0010, branch, imm 010.
  - 1101111 (jal): alu_op 0011, alu_pc, reg_write, branch, imm 100.
  - 1100111 (jalr): alu_op 0011, alu_pc, add_sum_reg, branch, reg_write.
  - 0110111 (lui): alu_op 0001, alu_src, reg_write, imm 011.
  - 0010111 (auipc): alu_op 0100, alu_src, alu_pc, reg_write, imm 011.
  - Any other opcode: all flags 0, illegal=1.
  - M op (opcode 0110011, funct7 0000001): muldiv=1 when ENABLE_M=1; illegal with flags 0 when ENABLE_M=0.
- Register usage:
  - rs1 is used by all decoded ops except lui, auipc, jal.
  - rs2 is used by R-type, store, branch.
- Load-use hazard (lu): valid_i & ex_valid_o & ex_mem_rd_o & ex_rd_o≠0 & (uses rs1 & rs1==ex_rd_o | uses rs2 & rs2==ex_rd_o).
- MUL/DIV counter:
  - Loaded with (funct3[2] ? DIV_LATENCY : MUL_LATENCY) − 1 when an M op enters EX.
  - Decrements by 1 per cycle while nonzero.
  - Width: $clog2(max latency + 1).
  - busy = (counter ≠ 0).
- stall_o = (busy | lu) & ~flush_i.
- EX register update each clock, priority order:
  1. flush_i: ex_valid_o←0, all flags←0, counter←0.
  2. busy: hold all ex_* unchanged.
  3. lu: insert bubble (ex_valid_o←0, flags←0); the instruction stays in ID.
  4. Otherwise: load the decode of instr_i; ex_valid_o←valid_i. When valid_i=0, flags←0.
- Latency:
  - An instruction presented without stall appears on ex_* 1 cycle later.
  - An M op holds EX for exactly its latency in cycles; stall_o is high for latency−1 cycles. Latency 1 gives no stall.
- Back-to-back M ops: the second enters on the cycle busy falls and reloads the counter, with no idle cycle.
- ex_rd_o==0 never triggers lu.
- Only the EX-stage load is checked for lu; later stages are covered by forwarding.
- Reset asserted mid MUL/DIV: counter and all state cleared immediately.

Test Plan:
- Reset: rst_n_i=0 with valid_i=1, instr_i=0x00500093 → all ex_* =0 and stall_o=0. After release, next edge: ex_alu_op_o=0101, ex_alu_src_o=1, ex_reg_write_o=1, ex_rd_o=1.
- Decode sweep: each legal opcode plus 0x0000007F → control bundles exactly as decoded above. 0x7F gives ex_illegal_o=1, ex_valid_o=1.
- Load-use, rs1 hit: lw x5,0(x1) then add x6,x5,x2 → stall_o=1 for one cycle, one bubble in EX, add in EX the following cycle. With the add replaced by add x6,x7,x2 → no stall.
- rd=x0 load: lw x0,0(x1) then add x6,x0,x2 → no stall.
- MUL/DIV (defaults):
  - mul (0x02208033) → stall_o high 2 cycles, ex_muldiv_o held 3 cycles.
  - div (0x0220C033) → stall_o high 33 cycles.
  - ENABLE_M=0 → the same mul decodes with ex_illegal_o=1 and no stall.
- Flush interactions:
  - flush_i during a div at counter=10 → stall_o=0 the same cycle, next edge ex_valid_o=0 and counter=0.
  - flush_i coincident with lu → bubble, no stall.

Source files
------------

// File: rtl/decode_ctrl_stage_if.sv
// ID/EX decode stage bus.
//   master : upstream side (drives valid_i, instr_i, flush_i; observes stall_o and ex_*)
//   slave  : decode_ctrl_stage itself
// Signals:
//   valid_i, instr_i[31:0] : instruction from IF/ID
//   flush_i                : kill the instruction in ID and EX
//   stall_o                : IF/ID must hold its contents
//   ex_*                   : ID/EX pipeline register contents (control bundle and fields)
interface decode_ctrl_stage_if #(
    parameter int unsigned REG_ADDR_W = 5
);
    logic                  valid_i;
    logic [31:0]           instr_i;
    logic                  flush_i;
    logic                  stall_o;
    logic                  ex_valid_o;
    logic [3:0]            ex_alu_op_o;
    logic [2:0]            ex_imm_select_o;
    logic                  ex_alu_src_o;
    logic                  ex_alu_pc_o;
    logic                  ex_add_sum_reg_o;
    logic                  ex_reg_write_o;
    logic                  ex_mem_rd_o;
    logic                  ex_mem_wr_o;
    logic                  ex_mem_to_reg_o;
    logic                  ex_branch_o;
    logic                  ex_muldiv_o;
    logic                  ex_illegal_o;
    logic [REG_ADDR_W-1:0] ex_rd_o;
    logic [REG_ADDR_W-1:0] ex_rs1_o;
    logic [REG_ADDR_W-1:0] ex_rs2_o;
    logic [2:0]            ex_funct3_o;
    logic [6:0]            ex_funct7_o;

    modport master (
        output valid_i, instr_i, flush_i,
        input  stall_o, ex_valid_o, ex_alu_op_o, ex_imm_select_o, ex_alu_src_o, ex_alu_pc_o,
        input  ex_add_sum_reg_o, ex_reg_write_o, ex_mem_rd_o, ex_mem_wr_o, ex_mem_to_reg_o,
        input  ex_branch_o, ex_muldiv_o, ex_illegal_o, ex_rd_o, ex_rs1_o, ex_rs2_o,
        input  ex_funct3_o, ex_funct7_o
    );

    modport slave (
        input  valid_i, instr_i, flush_i,
        output stall_o, ex_valid_o, ex_alu_op_o, ex_imm_select_o, ex_alu_src_o, ex_alu_pc_o,
        output ex_add_sum_reg_o, ex_reg_write_o, ex_mem_rd_o, ex_mem_wr_o, ex_mem_to_reg_o,
        output ex_branch_o, ex_muldiv_o, ex_illegal_o, ex_rd_o, ex_rs1_o, ex_rs2_o,
        output ex_funct3_o, ex_funct7_o
    );
endinterface

// File: rtl/decode_ctrl_stage.sv
// Registered RV32I/M instruction-decode control stage (ID/EX pipeline register).
// Decodes instr_i into a control bundle, detects load-use hazards against the load in EX,
// holds EX for multi-cycle MUL/DIV ops and applies flushes.
// Ports:
//   clk_i   : clock, rising edge
//   rst_n_i : asynchronous active-low reset
//   bus     : decode_ctrl_stage_if.slave (valid_i/instr_i/flush_i in; stall_o and ex_* out)
module decode_ctrl_stage #(
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned ENABLE_M    = 1,
    parameter int unsigned MUL_LATENCY = 3,
    parameter int unsigned DIV_LATENCY = 34
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    decode_ctrl_stage_if.slave   bus
);
    localparam int unsigned MaxLat = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);

    typedef struct packed {
        logic                  valid;
        logic [3:0]            alu_op;
        logic [2:0]            imm_sel;
        logic                  alu_src;
        logic                  alu_pc;
        logic                  add_sum_reg;
        logic                  reg_write;
        logic                  mem_rd;
        logic                  mem_wr;
        logic                  mem_to_reg;
        logic                  branch;
        logic                  muldiv;
        logic                  illegal;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [2:0]            funct3;
        logic [6:0]            funct7;
    } ex_bundle_t;

    ex_bundle_t     dec;
    ex_bundle_t     ex_d, ex_q;
    logic [CntW-1:0] cnt_d, cnt_q;
    logic            use_rs1, use_rs2;
    logic            busy, lu;
    logic [6:0]      opcode;
    logic [CntW-1:0] cnt_load;

    assign opcode   = bus.instr_i[6:0];
    // funct3[2] separates DIV/REM* from MUL*
    assign cnt_load = bus.instr_i[14] ? CntW'(DIV_LATENCY - 1) : CntW'(MUL_LATENCY - 1);

    // Combinational decode of the instruction sitting in ID.
    always_comb begin
        dec     = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        if (bus.valid_i) begin
            dec.valid  = 1'b1;
            dec.rd     = bus.instr_i[7 +: REG_ADDR_W];
            dec.rs1    = bus.instr_i[15 +: REG_ADDR_W];
            dec.rs2    = bus.instr_i[20 +: REG_ADDR_W];
            dec.funct3 = bus.instr_i[14:12];
            dec.funct7 = bus.instr_i[31:25];
            case (opcode)
                7'b0000000: ; // bubble
                7'b0110011: begin
                    if (bus.instr_i[31:25] == 7'b0000001 && ENABLE_M == 0) begin
                        dec.illegal = 1'b1;
                    end else begin
                        dec.alu_op    = 4'b0000;
                        dec.reg_write = 1'b1;
                        dec.muldiv    = (bus.instr_i[31:25] == 7'b0000001);
                        use_rs1       = 1'b1;
                        use_rs2       = 1'b1;
                    end
                end
                7'b0010011: begin
                    dec.alu_op    = 4'b0101;
                    dec.alu_src   = 1'b1;
                    dec.reg_write = 1'b1;
                    use_rs1       = 1'b1;
                end
                7'b0000011: begin
                    dec.alu_op     = 4'b0110;
                    dec.alu_src    = 1'b1;
                    dec.reg_write  = 1'b1;
                    dec.mem_rd     = 1'b1;
                    dec.mem_to_reg = 1'b1;
                    use_rs1        = 1'b1;
                end
                7'b0100011: begin
                    dec.alu_op  = 4'b0110;
                    dec.alu_src = 1'b1;
                    dec.mem_wr  = 1'b1;
                    dec.imm_sel = 3'b001;
                    use_rs1     = 1'b1;
                    use_rs2     = 1'b1;
                end
                7'b1100011: begin
                    dec.alu_op  = 4'b0010;
                    dec.branch  = 1'b1;
                    dec.imm_sel = 3'b010;
                    use_rs1     = 1'b1;
                    use_rs2     = 1'b1;
                end
                7'b1101111: begin
                    dec.alu_op    = 4'b0011;
                    dec.alu_pc    = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.branch    = 1'b1;
                    dec.imm_sel   = 3'b100;
                end
                7'b1100111: begin
                    dec.alu_op      = 4'b0011;
                    dec.alu_pc      = 1'b1;
                    dec.add_sum_reg = 1'b1;
                    dec.branch      = 1'b1;
                    dec.reg_write   = 1'b1;
                    use_rs1         = 1'b1;
                end
                7'b0110111: begin
                    dec.alu_op    = 4'b0001;
                    dec.alu_src   = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.imm_sel   = 3'b011;
                end
                7'b0010111: begin
                    dec.alu_op    = 4'b0100;
                    dec.alu_src   = 1'b1;
                    dec.alu_pc    = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.imm_sel   = 3'b011;
                end
                default: dec.illegal = 1'b1;
            endcase
        end
    end

    assign busy = (cnt_q != '0);
    // Only the load in EX is checked; later producers are covered by forwarding.
    assign lu = bus.valid_i & ex_q.valid & ex_q.mem_rd & (ex_q.rd != '0) &
                ((use_rs1 & (dec.rs1 == ex_q.rd)) | (use_rs2 & (dec.rs2 == ex_q.rd)));
    assign bus.stall_o = (busy | lu) & ~bus.flush_i;

    always_comb begin
        ex_d  = ex_q;
        cnt_d = cnt_q;
        if (bus.flush_i) begin
            ex_d  = '0;
            cnt_d = '0;
        end else if (busy) begin
            cnt_d = cnt_q - 1'b1;
        end else if (lu) begin
            ex_d = '0;
        end else begin
            ex_d = dec;
            if (dec.muldiv) begin
                cnt_d = cnt_load;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.ex_valid_o       = ex_q.valid;
    assign bus.ex_alu_op_o      = ex_q.alu_op;
    assign bus.ex_imm_select_o  = ex_q.imm_sel;
    assign bus.ex_alu_src_o     = ex_q.alu_src;
    assign bus.ex_alu_pc_o      = ex_q.alu_pc;
    assign bus.ex_add_sum_reg_o = ex_q.add_sum_reg;
    assign bus.ex_reg_write_o   = ex_q.reg_write;
    assign bus.ex_mem_rd_o      = ex_q.mem_rd;
    assign bus.ex_mem_wr_o      = ex_q.mem_wr;
    assign bus.ex_mem_to_reg_o  = ex_q.mem_to_reg;
    assign bus.ex_branch_o      = ex_q.branch;
    assign bus.ex_muldiv_o      = ex_q.muldiv;
    assign bus.ex_illegal_o     = ex_q.illegal;
    assign bus.ex_rd_o          = ex_q.rd;
    assign bus.ex_rs1_o         = ex_q.rs1;
    assign bus.ex_rs2_o         = ex_q.rs2;
    assign bus.ex_funct3_o      = ex_q.funct3;
    assign bus.ex_funct7_o      = ex_q.funct7;
endmodule
